// File: rtl/noc_arb_pkg.sv
// ----------------------------------------------------------------------------
// noc_arb_pkg : shared types and constants for the NoC link arbiter
// Rev 1.0     : initial release
// ----------------------------------------------------------------------------
`default_nettype none

package noc_arb_pkg;

  localparam int PKT_BYTES = 4;
  localparam int BYTE_W    = 8;
  localparam int STAT_W    = 16;

  typedef logic [31:0] pkt_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    DRAIN = 2'd2
  } arb_state_t;

  // Byte 0 is the most significant byte: the link is MSB first.
  function automatic logic [BYTE_W-1:0] pkt_byte(input pkt_t p, input logic [1:0] idx);
    case (idx)
      2'd0:    return p[31:24];
      2'd1:    return p[23:16];
      2'd2:    return p[15:8];
      default: return p[7:0];
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter : round-robin priority select with a registered last-grant pointer
// Rev 1.0    : initial release
// ----------------------------------------------------------------------------
`default_nettype none

module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_b,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] idx;
  logic             found;
  int               sum;

  // Search starts just after the last winner, so the last winner is lowest priority.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    sum       = 0;
    idx       = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      sum = int'(ptr_q) + off;
      idx = IDX_W'(sum % NUM_REQ);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

  always_comb begin
    ptr_d = advance ? grant_idx : ptr_q;
  end

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      ptr_q <= IDX_W'(NUM_REQ - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/noc_link_arbiter.sv
// ----------------------------------------------------------------------------
// noc_link_arbiter : round-robin scheduler serialising 32-bit packets onto a
//                    byte link; NOC_ARB_STATS_EN adds per-source grant counters
// Rev 1.0          : initial release
// ----------------------------------------------------------------------------
`default_nettype none

module noc_link_arbiter
  import noc_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic                            clk,
  input  logic                            rst_b,
  input  logic [NUM_REQ-1:0]              req,
  input  pkt_t [NUM_REQ-1:0]              pkt_in,
  output logic [NUM_REQ-1:0]              ack,
  input  logic                            free_in,
  output logic                            put_out,
  output logic [BYTE_W-1:0]               payload_out
`ifdef NOC_ARB_STATS_EN
  ,
  output logic [NUM_REQ-1:0][STAT_W-1:0]  grant_cnt
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_t         state_q, state_d;
  pkt_t               buf_q, buf_d;
  logic [1:0]         idx_q, idx_d;
  logic               put_q, put_d;
  logic [BYTE_W-1:0]  payload_q, payload_d;

  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               arb_en;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .clk       (clk),
    .rst_b     (rst_b),
    .req       (req),
    .advance   (arb_en),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // DRAIN arbitrates exactly like IDLE once the receiver reports free.
  always_comb begin
    arb_en = !rst_b && (state_q != SEND) && free_in && (|req);
    ack    = arb_en ? grant : '0;
  end

  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    idx_d     = idx_q;
    put_d     = 1'b0;
    payload_d = '0;
    case (state_q)
      SEND: begin
        if (idx_q == 2'(PKT_BYTES - 1)) begin
          state_d = DRAIN;
        end else begin
          idx_d     = idx_q + 2'd1;
          put_d     = 1'b1;
          payload_d = pkt_byte(buf_q, idx_q + 2'd1);
        end
      end
      DRAIN: begin
        if (free_in && !(|req)) state_d = IDLE;
      end
      default: ;
    endcase
    if (arb_en) begin
      buf_d     = pkt_in[grant_idx];
      idx_d     = 2'd0;
      state_d   = SEND;
      put_d     = 1'b1;
      payload_d = pkt_byte(pkt_in[grant_idx], 2'd0);
    end
  end

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      state_q   <= IDLE;
      buf_q     <= '0;
      idx_q     <= '0;
      put_q     <= 1'b0;
      payload_q <= '0;
    end else begin
      state_q   <= state_d;
      buf_q     <= buf_d;
      idx_q     <= idx_d;
      put_q     <= put_d;
      payload_q <= payload_d;
    end
  end

  assign put_out     = put_q;
  assign payload_out = payload_q;

`ifdef NOC_ARB_STATS_EN
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_stats
    logic [STAT_W-1:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = (ack[i] && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk or posedge rst_b) begin
      if (rst_b) cnt_q <= '0;
      else       cnt_q <= cnt_d;
    end

    assign grant_cnt[i] = cnt_q;
  end
`endif

  a_req_known: assert property (@(posedge clk) disable iff (rst_b) !$isunknown(req));

endmodule

`default_nettype wire

// File: tb/tb_noc_link_arbiter.sv
// ----------------------------------------------------------------------------
// tb_noc_link_arbiter : scoreboard bench for noc_link_arbiter
// Rev 1.0             : initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_noc_link_arbiter;

  localparam int N = 4;

  logic                clk = 1'b0;
  logic                rst_b = 1'b1;
  logic [N-1:0]        req = '0;
  logic [N-1:0][31:0]  pkt_in = '0;
  logic [N-1:0]        ack;
  logic                free_in;
  logic                put_out;
  logic [7:0]          payload_out;
`ifdef NOC_ARB_STATS_EN
  logic [N-1:0][15:0]  grant_cnt;
`endif

  logic rx_free = 1'b1;
  logic ovr_en  = 1'b0;
  logic ovr_val = 1'b0;
  assign free_in = ovr_en ? ovr_val : rx_free;

  noc_link_arbiter #(.NUM_REQ(N)) dut (
    .clk         (clk),
    .rst_b       (rst_b),
    .req         (req),
    .pkt_in      (pkt_in),
    .ack         (ack),
    .free_in     (free_in),
    .put_out     (put_out),
    .payload_out (payload_out)
`ifdef NOC_ARB_STATS_EN
    ,
    .grant_cnt   (grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Receiver: free flag is its registered view of ~put.
  always @(posedge clk) rx_free <= ~put_out;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          src;
    logic [31:0] pkt;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  byte_q[$];
  int          ack_cyc[$];
  int          checks = 0;
  int          errors = 0;

  exp_t        mon_e;
  logic [7:0]  mon_b;

  always @(negedge clk) begin
    if (!rst_b) begin
      if (ack != '0) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_ack: unexpected ack=%b, none expected", ack);
        end else begin
          mon_e = exp_q.pop_front();
          if (ack !== (N'(1) << mon_e.src)) begin
            errors++;
            $display("FAIL sb_ack: got %b expected %b", ack, N'(1) << mon_e.src);
          end
          for (int b = 0; b < 4; b++) byte_q.push_back(mon_e.pkt[31-8*b -: 8]);
        end
        ack_cyc.push_back(cyc);
      end
      checks++;
      if (put_out === 1'b1) begin
        if (byte_q.size() == 0) begin
          errors++;
          $display("FAIL sb_byte: unexpected byte %h, none expected", payload_out);
        end else begin
          mon_b = byte_q.pop_front();
          if (payload_out !== mon_b) begin
            errors++;
            $display("FAIL sb_byte: got %h expected %h", payload_out, mon_b);
          end
        end
      end else if (put_out !== 1'b0 || payload_out !== 8'h00) begin
        errors++;
        $display("FAIL sb_idle_link: put=%b payload=%h expected put=0 payload=00", put_out, payload_out);
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst_b = 1'b1;
    req   = '0;
    exp_q.delete();
    byte_q.delete();
    ack_cyc.delete();
    repeat (2) @(posedge clk);
    #1 rst_b = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && byte_q.size() == 0 && put_out === 1'b0 && free_in === 1'b1) return;
    end
    checks++;
    errors++;
    $display("FAIL wait_idle: link still busy after 60 cycles, exp=%0d bytes=%0d", exp_q.size(), byte_q.size());
  endtask

  // Holds r until n acks are seen, then drops it; got reports how many arrived.
  task automatic grant_n(input logic [N-1:0] r, input int n, output int got);
    got = 0;
    @(posedge clk); #1 req = r;
    for (int k = 0; k < 20 * n && got < n; k++) begin
      @(negedge clk);
      if (ack != '0) got++;
    end
    @(posedge clk); #1 req = '0;
    checks++;
    if (got != n) begin
      errors++;
      $display("FAIL grant_count: got %0d acks expected %0d", got, n);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (put_out !== 1'b0 || payload_out !== 8'h00 || ack !== '0) begin
      errors++;
      $display("FAIL reset_outputs: put=%b payload=%h ack=%b expected 0/00/0000", put_out, payload_out, ack);
    end
    @(posedge clk); #1 rst_b = 1'b0;
    @(posedge clk); #1;
    pkt_in = {32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000};
    exp_q.push_back('{src: 0, pkt: 32'h00000000});
    req = 4'b1111;
    @(negedge clk);
    checks++;
    if (ack !== 4'b0001) begin
      errors++;
      $display("FAIL reset_first_grant: ack=%b expected 0001", ack);
    end
    @(posedge clk); #1 req = '0;
    wait_idle();
  endtask

  task automatic test_single();
    logic [7:0] exp_b [4];
    exp_b = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    @(posedge clk); #1;
    pkt_in[0] = 32'hA1B2C3D4;
    exp_q.push_back('{src: 0, pkt: 32'hA1B2C3D4});
    req = 4'b0001;
    @(negedge clk);
    checks++;
    if (ack !== 4'b0001) begin
      errors++;
      $display("FAIL single_ack: ack=%b expected 0001", ack);
    end
    @(posedge clk); #1 req = '0;
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      checks++;
      if (put_out !== 1'b1 || payload_out !== exp_b[b] || ack !== '0) begin
        errors++;
        $display("FAIL single_byte%0d: put=%b payload=%h ack=%b expected 1/%h/0000", b, put_out, payload_out, ack, exp_b[b]);
      end
    end
    @(negedge clk);
    checks++;
    if (put_out !== 1'b0) begin
      errors++;
      $display("FAIL single_end: put=%b expected 0", put_out);
    end
    wait_idle();
  endtask

  task automatic test_round_robin();
    int got;
    do_reset();
    pkt_in = {32'h3A3B3C3D, 32'h2A2B2C2D, 32'h1A1B1C1D, 32'h0A0B0C0D};
    for (int k = 0; k < 5; k++) exp_q.push_back('{src: k % N, pkt: pkt_in[k % N]});
    grant_n(4'b1111, 5, got);
    checks++;
    if (ack_cyc.size() != 5) begin
      errors++;
      $display("FAIL rr_ack_count: got %0d expected 5", ack_cyc.size());
    end else begin
      for (int i = 1; i < 5; i++) begin
        checks++;
        if (ack_cyc[i] - ack_cyc[i-1] != 6) begin
          errors++;
          $display("FAIL rr_period%0d: got %0d cycles expected 6", i, ack_cyc[i] - ack_cyc[i-1]);
        end
      end
    end
    wait_idle();
  endtask

  task automatic test_free_stall();
    int bad;
    bad = 0;
    @(posedge clk); #1;
    ovr_en    = 1'b1;
    ovr_val   = 1'b0;
    pkt_in[2] = 32'h5A6B7C8D;
    req       = 4'b0100;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (ack !== '0 || put_out !== 1'b0) begin
        errors++;
        $display("FAIL stall_cycle%0d: ack=%b put=%b expected 0000/0", i, ack, put_out);
      end
    end
    exp_q.push_back('{src: 2, pkt: 32'h5A6B7C8D});
    @(posedge clk); #1 ovr_val = 1'b1;
    @(negedge clk);
    checks++;
    if (ack !== 4'b0100) begin
      errors++;
      $display("FAIL stall_release_ack: ack=%b expected 0100", ack);
    end
    @(posedge clk); #1;
    req    = '0;
    ovr_en = 1'b0;
    wait_idle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    pkt_in[3] = 32'hDEADBEEF;
    exp_q.push_back('{src: 3, pkt: 32'hDEADBEEF});
    req = 4'b1000;
    @(negedge clk);
    checks++;
    if (ack !== 4'b1000) begin
      errors++;
      $display("FAIL mid_ack3: ack=%b expected 1000", ack);
    end
    @(posedge clk); #1 req = '0;
    @(posedge clk); #1;
    rst_b = 1'b1;
    exp_q.delete();
    byte_q.delete();
    #1;
    checks++;
    if (put_out !== 1'b0 || payload_out !== 8'h00 || ack !== '0) begin
      errors++;
      $display("FAIL mid_abort: put=%b payload=%h ack=%b expected 0/00/0000", put_out, payload_out, ack);
    end
    repeat (2) @(posedge clk);
    #1 rst_b = 1'b0;
    pkt_in[1] = 32'h01020304;
    pkt_in[3] = 32'h05060708;
    exp_q.push_back('{src: 1, pkt: 32'h01020304});
    req = 4'b1010;
    @(negedge clk);
    checks++;
    if (ack !== 4'b0010) begin
      errors++;
      $display("FAIL mid_regrant: ack=%b expected 0010", ack);
    end
    @(posedge clk); #1 req = '0;
    wait_idle();
  endtask

`ifdef NOC_ARB_STATS_EN
  task automatic test_stats();
    int got;
    do_reset();
    pkt_in[2] = 32'hC0FFEE02;
    for (int k = 0; k < 3; k++) exp_q.push_back('{src: 2, pkt: 32'hC0FFEE02});
    grant_n(4'b0100, 3, got);
    wait_idle();
    for (int i = 0; i < N; i++) begin
      checks++;
      if (grant_cnt[i] !== ((i == 2) ? 16'd3 : 16'd0)) begin
        errors++;
        $display("FAIL stats_cnt%0d: got %0d expected %0d", i, grant_cnt[i], (i == 2) ? 3 : 0);
      end
    end
    force dut.g_stats[2].cnt_q = 16'hFFFE;
    #1 release dut.g_stats[2].cnt_q;
    for (int k = 0; k < 3; k++) exp_q.push_back('{src: 2, pkt: 32'hC0FFEE02});
    grant_n(4'b0100, 3, got);
    wait_idle();
    checks++;
    if (grant_cnt[2] !== 16'hFFFF) begin
      errors++;
      $display("FAIL stats_saturate: got %h expected FFFF", grant_cnt[2]);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_free_stall();
    test_reset_mid();
`ifdef NOC_ARB_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
